trigger_seq: RTL and testbench

- Parametrised successor of the single-stage trigger: TMN mask/value matchers with selectable match modes, feeding a TSN-stage sequencer with per-stage hit counters.
- Sits between capture sampler and sample buffer.
- Passes the sample stream through a 1-deep register slice and tags each beat with matcher hits, stage-advance and fire flags.
- Configured over the write-only system bus.

---
 rtl/trigger_seq_pkg.sv | 33 +++
 rtl/trigger_matcher.sv | 37 +++
 rtl/trigger_seq.sv | 266 ++++++++++++++++++++++++++
 tb/tb_trigger_seq.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trigger_seq_pkg.sv
// trigger_seq_pkg
//   Shared types and constants for the trigger sequencer: matcher mode
//   encoding, sequencer state encoding, register word addresses and
//   stage-config field offsets.
package trigger_seq_pkg;

  typedef enum logic [1:0] {
    MODE_LEVEL  = 2'b00,
    MODE_RISE   = 2'b01,
    MODE_CHANGE = 2'b10,
    MODE_OFF    = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FIRED = 2'd2
  } state_e;

  localparam logic [7:0] ADR_CTRL    = 8'h00;
  localparam logic [7:0] ADR_MODE    = 8'h01;
  localparam logic [7:0] ADR_MATCH   = 8'h10;
  localparam logic [7:0] ADR_STAGE   = 8'h20;
  localparam logic [7:0] ADR_TIMEOUT = 8'h30;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_ARM_BIT = 1;

  localparam int SCF_SEL_LSB  = 0;
  localparam int SCF_COMB_BIT = 8;
  localparam int SCF_CNT_LSB  = 16;

endpackage

// File: rtl/trigger_matcher.sv
// trigger_matcher
//   One mask/value matcher producing a combinational hit for the current
//   sample.
//   sample - sample being transferred now
//   prev   - previously transferred sample
//   mask   - bits taking part in the compare
//   value  - compare value (ignored in change mode)
//   mode   - LEVEL / RISE / CHANGE / OFF
//   hit    - match result
module trigger_matcher
  import trigger_seq_pkg::*;
#(
  parameter int SDW = 32
) (
  input  logic [SDW-1:0] sample,
  input  logic [SDW-1:0] prev,
  input  logic [SDW-1:0] mask,
  input  logic [SDW-1:0] value,
  input  mode_e          mode,
  output logic           hit
);

  logic level_now;
  logic level_prev;

  always_comb begin
    level_now  = ((sample ^ value) & mask) == '0;
    level_prev = ((prev ^ value) & mask) == '0;
    case (mode)
      MODE_LEVEL:  hit = level_now;
      MODE_RISE:   hit = level_now & ~level_prev;
      MODE_CHANGE: hit = ((sample ^ prev) & mask) != '0;
      default:     hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/trigger_seq.sv
// trigger_seq
//   Multi-matcher, multi-stage trigger sitting between the capture sampler
//   and the sample buffer. Samples pass through a 1-deep register slice and
//   each beat is tagged with matcher hits, a stage-advance flag and a fire
//   flag. Configured through a write-only register bus.
//   Optional build macro TRIGGER_SEQ_TIMEOUT_EN adds per-stage timeouts.
//
//   clk, rst         - clock, async active-high reset
//   bus_w*           - register write port (always ready outside reset)
//   sti_t*           - input sample stream
//   sto_t*           - output sample stream; sto_tevent = {fire, advance, hits}
//
//   state | meaning
//   IDLE  | disabled or never armed, no stage evaluation
//   ARMED | evaluating the current stage on each input transfer
//   FIRED | last stage completed, holding until re-armed
module trigger_seq
  import trigger_seq_pkg::*;
#(
  parameter int BAW = 8,
  parameter int BDW = 32,
  parameter int SDW = 32,
  parameter int TMN = 4,
  parameter int TSN = 4,
  parameter int TCW = 16
) (
  input  logic           clk,
  input  logic           rst,
  output logic           bus_wready,
  input  logic           bus_wvalid,
  input  logic [BAW-1:0] bus_waddr,
  input  logic [BDW-1:0] bus_wdata,
  output logic           sti_tready,
  input  logic           sti_tvalid,
  input  logic [SDW-1:0] sti_tdata,
  input  logic           sto_tready,
  output logic           sto_tvalid,
  output logic [TMN+1:0] sto_tevent,
  output logic [SDW-1:0] sto_tdata
);

  localparam int SEW = TMN + 2;
  localparam int SIW = (TSN > 1) ? $clog2(TSN) : 1;

  logic           en_q, en_d;
  logic [2*TMN-1:0] mode_q, mode_d;
  logic [SDW-1:0] mask_q [TMN];
  logic [SDW-1:0] mask_d [TMN];
  logic [SDW-1:0] value_q [TMN];
  logic [SDW-1:0] value_d [TMN];
  logic [TMN-1:0] sel_q [TSN];
  logic [TMN-1:0] sel_d [TSN];
  logic [TSN-1:0] comb_q, comb_d;
  logic [TCW-1:0] hcnt_q [TSN];
  logic [TCW-1:0] hcnt_d [TSN];
`ifdef TRIGGER_SEQ_TIMEOUT_EN
  logic [TCW-1:0] tmo_q [TSN];
  logic [TCW-1:0] tmo_d [TSN];
  logic [TCW-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

  state_e         state_q, state_d;
  logic [SIW-1:0] stage_q, stage_d;
  logic [TCW-1:0] cnt_q, cnt_d;
  logic [SDW-1:0] prev_q, prev_d;
  logic           sto_tvalid_q, sto_tvalid_d;
  logic [SEW-1:0] sto_tevent_q, sto_tevent_d;
  logic [SDW-1:0] sto_tdata_q, sto_tdata_d;

  logic           wr;
  logic           arm_go;
  logic           in_xfer;
  logic [TMN-1:0] hit;
  logic [TMN-1:0] sel_cur;
  logic [TCW-1:0] target;
  logic           cond;
  logic           reach;
  logic           adv;
  logic           fire;
  logic           unused_wdata;

  assign unused_wdata = ^bus_wdata;

  assign bus_wready = ~rst;
  assign wr         = bus_wvalid & bus_wready;
  assign sti_tready = sto_tready | ~sto_tvalid_q;
  assign in_xfer    = sti_tvalid & sti_tready;

  // Register write decode
  always_comb begin
    en_d   = en_q;
    mode_d = mode_q;
    mask_d = mask_q;
    value_d = value_q;
    sel_d  = sel_q;
    comb_d = comb_q;
    hcnt_d = hcnt_q;
`ifdef TRIGGER_SEQ_TIMEOUT_EN
    tmo_d  = tmo_q;
`endif
    arm_go = 1'b0;
    if (wr) begin
      if (bus_waddr == BAW'(ADR_CTRL)) begin
        en_d   = bus_wdata[CTRL_EN_BIT];
        // Arm only takes when the same write also enables the block
        arm_go = bus_wdata[CTRL_ARM_BIT] & bus_wdata[CTRL_EN_BIT];
      end
      if (bus_waddr == BAW'(ADR_MODE)) mode_d = bus_wdata[2*TMN-1:0];
      for (int m = 0; m < TMN; m++) begin
        if (bus_waddr == BAW'(ADR_MATCH + 2*m))     mask_d[m]  = SDW'(bus_wdata);
        if (bus_waddr == BAW'(ADR_MATCH + 2*m + 1)) value_d[m] = SDW'(bus_wdata);
      end
      for (int s = 0; s < TSN; s++) begin
        if (bus_waddr == BAW'(ADR_STAGE + s)) begin
          sel_d[s]  = bus_wdata[SCF_SEL_LSB +: TMN];
          comb_d[s] = bus_wdata[SCF_COMB_BIT];
          hcnt_d[s] = bus_wdata[SCF_CNT_LSB +: TCW];
        end
`ifdef TRIGGER_SEQ_TIMEOUT_EN
        if (bus_waddr == BAW'(ADR_TIMEOUT + s)) tmo_d[s] = bus_wdata[TCW-1:0];
`endif
      end
    end
  end

  for (genvar m = 0; m < TMN; m++) begin : g_match
    trigger_matcher #(.SDW(SDW)) u_match (
      .sample (sti_tdata),
      .prev   (prev_q),
      .mask   (mask_q[m]),
      .value  (value_q[m]),
      .mode   (mode_e'(mode_q[2*m +: 2])),
      .hit    (hit[m])
    );
  end

  // Stage condition; an empty select never matches
  always_comb begin
    sel_cur = sel_q[stage_q];
    cond    = (sel_cur != '0) &&
              (comb_q[stage_q] ? ((hit & sel_cur) != '0) : ((hit & sel_cur) == sel_cur));
    target  = (hcnt_q[stage_q] == '0) ? TCW'(1) : hcnt_q[stage_q];
    // >= rather than == keeps the counter saturated if the count is lowered mid-run
    reach   = ({1'b0, cnt_q} + 1'b1) >= {1'b0, target};
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    adv     = 1'b0;
    fire    = 1'b0;
`ifdef TRIGGER_SEQ_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
`endif
    if (arm_go) begin
      state_d = ST_ARMED;
      stage_d = '0;
      cnt_d   = '0;
`ifdef TRIGGER_SEQ_TIMEOUT_EN
      tmo_cnt_d = '0;
`endif
    end else if (!en_q) begin
      state_d = ST_IDLE;
      stage_d = '0;
      cnt_d   = '0;
    end else if (state_q == ST_ARMED && in_xfer) begin
      if (cond && reach) begin
        adv   = 1'b1;
        cnt_d = '0;
`ifdef TRIGGER_SEQ_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
        if (stage_q == SIW'(TSN-1)) begin
          state_d = ST_FIRED;
          fire    = 1'b1;
          stage_d = '0;
        end else begin
          stage_d = stage_q + 1'b1;
        end
      end else begin
        if (cond) cnt_d = cnt_q + 1'b1;
`ifdef TRIGGER_SEQ_TIMEOUT_EN
        if (tmo_q[stage_q] != '0) begin
          if (({1'b0, tmo_cnt_q} + 1'b1) >= {1'b0, tmo_q[stage_q]}) begin
            stage_d   = '0;
            cnt_d     = '0;
            tmo_cnt_d = '0;
          end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
          end
        end
`endif
      end
    end
  end

  // Output register slice
  always_comb begin
    sto_tvalid_d = sto_tvalid_q;
    sto_tevent_d = sto_tevent_q;
    sto_tdata_d  = sto_tdata_q;
    prev_d       = prev_q;
    if (in_xfer) begin
      sto_tvalid_d = 1'b1;
      sto_tevent_d = {fire, adv, hit};
      sto_tdata_d  = sti_tdata;
      prev_d       = sti_tdata;
    end else if (sto_tready) begin
      sto_tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q   <= 1'b0;
      mode_q <= '0;
      comb_q <= '0;
      for (int m = 0; m < TMN; m++) begin
        mask_q[m]  <= '0;
        value_q[m] <= '0;
      end
      for (int s = 0; s < TSN; s++) begin
        sel_q[s]  <= '0;
        hcnt_q[s] <= '0;
`ifdef TRIGGER_SEQ_TIMEOUT_EN
        tmo_q[s]  <= '0;
`endif
      end
`ifdef TRIGGER_SEQ_TIMEOUT_EN
      tmo_cnt_q <= '0;
`endif
      state_q      <= ST_IDLE;
      stage_q      <= '0;
      cnt_q        <= '0;
      prev_q       <= '0;
      sto_tvalid_q <= 1'b0;
      sto_tevent_q <= '0;
      sto_tdata_q  <= '0;
    end else begin
      en_q    <= en_d;
      mode_q  <= mode_d;
      mask_q  <= mask_d;
      value_q <= value_d;
      sel_q   <= sel_d;
      comb_q  <= comb_d;
      hcnt_q  <= hcnt_d;
`ifdef TRIGGER_SEQ_TIMEOUT_EN
      tmo_q     <= tmo_d;
      tmo_cnt_q <= tmo_cnt_d;
`endif
      state_q      <= state_d;
      stage_q      <= stage_d;
      cnt_q        <= cnt_d;
      prev_q       <= prev_d;
      sto_tvalid_q <= sto_tvalid_d;
      sto_tevent_q <= sto_tevent_d;
      sto_tdata_q  <= sto_tdata_d;
    end
  end

  assign sto_tvalid = sto_tvalid_q;
  assign sto_tevent = sto_tevent_q;
  assign sto_tdata  = sto_tdata_q;

endmodule

// File: tb/tb_trigger_seq.sv
// tb_trigger_seq
//   Directed bench for trigger_seq with two stages and four matchers.
//   Event encoding at this size: [3:0] hits, [4] advance, [5] fire.
//   Honours TRIGGER_SEQ_TIMEOUT_EN for the timeout sequence.
module tb_trigger_seq;

  localparam int BAW = 8;
  localparam int BDW = 32;
  localparam int SDW = 32;
  localparam int TMN = 4;
  localparam int TSN = 2;
  localparam int TCW = 16;

  logic           clk;
  logic           rst;
  logic           bus_wready;
  logic           bus_wvalid;
  logic [BAW-1:0] bus_waddr;
  logic [BDW-1:0] bus_wdata;
  logic           sti_tready;
  logic           sti_tvalid;
  logic [SDW-1:0] sti_tdata;
  logic           sto_tready;
  logic           sto_tvalid;
  logic [TMN+1:0] sto_tevent;
  logic [SDW-1:0] sto_tdata;

  trigger_seq #(
    .BAW(BAW), .BDW(BDW), .SDW(SDW), .TMN(TMN), .TSN(TSN), .TCW(TCW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus_wready (bus_wready),
    .bus_wvalid (bus_wvalid),
    .bus_waddr  (bus_waddr),
    .bus_wdata  (bus_wdata),
    .sti_tready (sti_tready),
    .sti_tvalid (sti_tvalid),
    .sti_tdata  (sti_tdata),
    .sto_tready (sto_tready),
    .sto_tvalid (sto_tvalid),
    .sto_tevent (sto_tevent),
    .sto_tdata  (sto_tdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int          seg;
    logic [31:0] data;
    logic [5:0]  ev;
  } vec_t;

  vec_t vt[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    bus_wvalid = 1'b1;
    bus_waddr  = a;
    bus_wdata  = d;
    @(posedge clk); #1;
    bus_wvalid = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d, input logic [5:0] ev, input string name);
    sti_tvalid = 1'b1;
    sti_tdata  = d;
    @(posedge clk); #1;
    sti_tvalid = 1'b0;
    check($sformatf("%s valid", name), 32'(sto_tvalid), 32'd1);
    check($sformatf("%s data", name), sto_tdata, d);
    check($sformatf("%s event", name), 32'(sto_tevent), 32'(ev));
  endtask

  task automatic setup_seg(input int seg);
    case (seg)
      1: begin
        bus_write(8'h01, 32'h0000_00FC);
        bus_write(8'h10, 32'hFFFF_0000);
        bus_write(8'h11, 32'h1234_0000);
        bus_write(8'h20, 32'h0001_0001);
        bus_write(8'h21, 32'h0001_0001);
      end
      2: begin
        bus_write(8'h01, 32'h0000_00F7);
        bus_write(8'h12, 32'h0000_0001);
        bus_write(8'h13, 32'h0000_0001);
        bus_write(8'h20, 32'h0003_0002);
        bus_write(8'h21, 32'h0001_0002);
      end
      3: begin
        bus_write(8'h01, 32'h0000_00C0);
        bus_write(8'h10, 32'h0000_00FF);
        bus_write(8'h11, 32'h0000_00A0);
        bus_write(8'h12, 32'h0000_00FF);
        bus_write(8'h13, 32'h0000_00B1);
        bus_write(8'h14, 32'h0000_00FF);
        bus_write(8'h15, 32'h0000_00C2);
        bus_write(8'h20, 32'h0000_0001);
        bus_write(8'h21, 32'h0001_0106);
      end
      5: begin
        bus_write(8'h01, 32'h0000_00F0);
        bus_write(8'h10, 32'h0000_00F0);
        bus_write(8'h11, 32'h0000_0010);
        bus_write(8'h12, 32'h0000_000F);
        bus_write(8'h13, 32'h0000_0001);
        bus_write(8'h20, 32'h0001_0003);
        bus_write(8'h21, 32'h0001_0000);
      end
      6: begin
        bus_write(8'h01, 32'h0000_00BF);
        bus_write(8'h16, 32'h0000_FF00);
        bus_write(8'h20, 32'h0002_0008);
        bus_write(8'h21, 32'h0001_0008);
      end
      default: ;
    endcase
    bus_write(8'h00, 32'h0000_0003);
  endtask

  initial begin
    int cur;
    int sent;
    logic in_x, out_x;
    logic [31:0] smp_d;
    logic [5:0]  smp_e;
    logic [31:0] got_d[$];
    logic [5:0]  got_e[$];

    // level match on upper half, two single-hit stages
    vt.push_back('{1, 32'h0000_1111, 6'h00});
    vt.push_back('{1, 32'h1234_5678, 6'h11});
    vt.push_back('{1, 32'h1234_5678, 6'h31});
    vt.push_back('{1, 32'h1234_5678, 6'h01});
    // rising edges on bit 0, stage 0 needs three of them
    vt.push_back('{2, 32'h0, 6'h00});
    vt.push_back('{2, 32'h1, 6'h02});
    vt.push_back('{2, 32'h1, 6'h00});
    vt.push_back('{2, 32'h0, 6'h00});
    vt.push_back('{2, 32'h1, 6'h02});
    vt.push_back('{2, 32'h0, 6'h00});
    vt.push_back('{2, 32'h1, 6'h12});
    vt.push_back('{2, 32'h0, 6'h00});
    vt.push_back('{2, 32'h1, 6'h32});
    // m0 then any of m1|m2, then FIRED holds
    vt.push_back('{3, 32'hA0, 6'h11});
    vt.push_back('{3, 32'h00, 6'h00});
    vt.push_back('{3, 32'hC2, 6'h34});
    vt.push_back('{3, 32'hA0, 6'h01});
    vt.push_back('{3, 32'hB1, 6'h02});
    // re-arm with the same config
    vt.push_back('{4, 32'hB1, 6'h02});
    vt.push_back('{4, 32'hA0, 6'h11});
    vt.push_back('{4, 32'hB1, 6'h32});
    // all-of combine, then an empty select that never matches
    vt.push_back('{5, 32'h10, 6'h01});
    vt.push_back('{5, 32'h11, 6'h13});
    vt.push_back('{5, 32'h11, 6'h03});
    // change mode on bits 15:8
    vt.push_back('{6, 32'h0011, 6'h00});
    vt.push_back('{6, 32'h0111, 6'h08});
    vt.push_back('{6, 32'h0112, 6'h00});
    vt.push_back('{6, 32'h0212, 6'h18});
    vt.push_back('{6, 32'h0212, 6'h00});
    vt.push_back('{6, 32'h0312, 6'h38});

    rst        = 1'b1;
    bus_wvalid = 1'b0;
    bus_waddr  = '0;
    bus_wdata  = '0;
    sti_tvalid = 1'b0;
    sti_tdata  = '0;
    sto_tready = 1'b1;
    #12;
    check("reset tvalid", 32'(sto_tvalid), 32'd0);
    check("reset tevent", 32'(sto_tevent), 32'd0);
    check("reset tdata", sto_tdata, 32'd0);
    check("reset wready", 32'(bus_wready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("wready after reset", 32'(bus_wready), 32'd1);
    check("sti_tready idle", 32'(sti_tready), 32'd1);

    cur = -1;
    foreach (vt[i]) begin
      if (vt[i].seg != cur) begin
        cur = vt[i].seg;
        setup_seg(cur);
      end
      beat(vt[i].data, vt[i].ev, $sformatf("seg%0d v%0d", cur, i));
    end

    // Arm written in the same cycle as a matching beat
    setup_seg(3);
    beat(32'hA0, 6'h11, "armsim pre");
    bus_wvalid = 1'b1;
    bus_waddr  = 8'h00;
    bus_wdata  = 32'h3;
    sti_tvalid = 1'b1;
    sti_tdata  = 32'hA0;
    @(posedge clk); #1;
    bus_wvalid = 1'b0;
    sti_tvalid = 1'b0;
    check("armsim valid", 32'(sto_tvalid), 32'd1);
    check("armsim event", 32'(sto_tevent), 32'h01);
    beat(32'hA0, 6'h11, "armsim post");

    // Stage-1 timeout of four transfers
    bus_write(8'h31, 32'd4);
    bus_write(8'h00, 32'h3);
    beat(32'hA0, 6'h11, "tmo adv");
    for (int k = 0; k < 4; k++) beat(32'h00, 6'h00, $sformatf("tmo idle%0d", k));
`ifdef TRIGGER_SEQ_TIMEOUT_EN
    beat(32'hB1, 6'h02, "tmo back stage0");
    beat(32'hA0, 6'h11, "tmo readv");
`else
    beat(32'hB1, 6'h32, "tmo still stage1");
`endif

    // Backpressure: sink stalls for five cycles mid-stream
    bus_write(8'h01, 32'h0000_00FC);
    bus_write(8'h10, 32'h0000_00FF);
    bus_write(8'h11, 32'h0000_0005);
    bus_write(8'h20, 32'h0000_0000);
    bus_write(8'h00, 32'h3);
    sent = 0;
    for (int c = 0; c < 30; c++) begin
      sto_tready = !(c >= 4 && c < 9);
      sti_tvalid = (sent < 8);
      sti_tdata  = 32'(sent + 1);
      #4;
      if (c == 4) check("bp throughput", 32'(sent), 32'd4);
      if (c == 6) check("bp tready low", 32'(sti_tready), 32'd0);
      in_x  = sti_tvalid & sti_tready;
      out_x = sto_tvalid & sto_tready;
      smp_d = sto_tdata;
      smp_e = sto_tevent;
      @(posedge clk); #1;
      if (out_x) begin
        got_d.push_back(smp_d);
        got_e.push_back(smp_e);
      end
      if (in_x) sent++;
    end
    sti_tvalid = 1'b0;
    sto_tready = 1'b1;
    check("bp count", 32'(got_d.size()), 32'd8);
    for (int i = 0; i < got_d.size(); i++) begin
      check($sformatf("bp data%0d", i), got_d[i], 32'(i + 1));
      check($sformatf("bp event%0d", i), 32'(got_e[i]), (i + 1 == 5) ? 32'h01 : 32'h00);
    end

    // Reset while ARMED with a beat in the slice
    beat(32'h05, 6'h01, "rst pre");
    #2;
    rst = 1'b1;
    #1;
    check("rst mid tvalid", 32'(sto_tvalid), 32'd0);
    check("rst mid tevent", 32'(sto_tevent), 32'd0);
    check("rst mid tdata", sto_tdata, 32'd0);
    check("rst mid wready", 32'(bus_wready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    // cleared config: all matchers level with empty mask, sequencer idle
    beat(32'hA0, 6'h0F, "rst post");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
